// File: rtl/itrx_aib_phy_rst_seq.sv
// itrx_aib_phy_rst_seq: staged TX/RX reset release for one AIB channel, gated on config and partner ready
module itrx_aib_phy_rst_seq #(
  parameter int CNT_W  = 8,
  parameter int TX_DLY = 16,
  parameter int RX_DLY = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scan_mode,
  input  logic       conf_done,
  input  logic       sw_rst_req,
  input  logic       remote_rdy,
  output logic       tx_rst_n,
  output logic       rx_rst_n,
  output logic       link_up,
  output logic [2:0] seq_state
);
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    TX_WAIT  = 3'd1,
    WAIT_REM = 3'd2,
    RX_WAIT  = 3'd3,
    LINK     = 3'd4
  } state_t;
  localparam logic [CNT_W-1:0] TX_T = CNT_W'(TX_DLY - 1);
  localparam logic [CNT_W-1:0] RX_T = CNT_W'(RX_DLY - 1);
  state_t           r_state, w_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_sync;
  logic             r_tx, r_rx, r_link;
  logic             w_rdy;
  assign w_rdy = r_sync[1];
  always_comb begin
    w_nxt = IDLE;
    if (!conf_done && r_state != IDLE) w_nxt = IDLE;
    else if (sw_rst_req) w_nxt = IDLE;
    else if (!w_rdy && (r_state == RX_WAIT || r_state == LINK)) w_nxt = WAIT_REM;
    else
      case (r_state)
        IDLE:     w_nxt = conf_done ? TX_WAIT : IDLE;
        TX_WAIT:  w_nxt = (r_cnt == TX_T) ? WAIT_REM : TX_WAIT;
        WAIT_REM: w_nxt = w_rdy ? RX_WAIT : WAIT_REM;
        RX_WAIT:  w_nxt = (r_cnt == RX_T) ? LINK : RX_WAIT;
        LINK:     w_nxt = LINK;
        default:  w_nxt = IDLE;
      endcase
  end
  // outputs are decoded from the next state so they change on the transition edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sync  <= '0;
      r_tx    <= 1'b0;
      r_rx    <= 1'b0;
      r_link  <= 1'b0;
    end else begin
      r_state <= w_nxt;
      r_cnt   <= (w_nxt == r_state && (r_state == TX_WAIT || r_state == RX_WAIT)) ? r_cnt + 1'b1 : '0;
      r_sync  <= {r_sync[0], remote_rdy};
      r_tx    <= (w_nxt == WAIT_REM || w_nxt == RX_WAIT || w_nxt == LINK);
      r_rx    <= (w_nxt == LINK);
      r_link  <= (w_nxt == LINK);
    end
  end
  assign tx_rst_n  = scan_mode ? rst_n : r_tx;
  assign rx_rst_n  = scan_mode ? rst_n : r_rx;
  assign link_up   = r_link;
  assign seq_state = r_state;
endmodule

// File: doc/itrx_aib_phy_rst_seq.md
# itrx_aib_phy_rst_seq

Staged reset sequencer for one AIB channel that sits directly downstream of the per-clock-domain reset synchronizer. It consumes the synchronized channel reset and releases the transmit-path and receive-path resets in order. TX release waits for configuration plus a programmable delay. RX release also waits for the link partner's ready indication, synchronized internally, plus a second delay. It reports link-up and its state for CSR visibility, and it bypasses sequencing in DFT scan mode.

## Interface
Parameters:
- CNT_W, 8, width of the delay counter.
- TX_DLY, 16, cycles from configuration-done to TX reset release. Legal range 1..2^CNT_W.
- RX_DLY, 16, cycles from synchronized remote-ready to RX reset release. Legal range 1..2^CNT_W.

Ports:
- clk  input  1  channel clock.
- rst_n  input  1  reset, asynchronous, active-low. Driven by the upstream synchronizer, so deassertion is synchronous to clk.
- scan_mode  input  1  DFT bypass: tx_rst_n and rx_rst_n follow rst_n combinationally.
- conf_done  input  1  channel configuration complete, synchronous to clk, level.
- sw_rst_req  input  1  single-cycle software re-sequence request, synchronous to clk.
- remote_rdy  input  1  partner ready, asynchronous. Passes through a 2-flop synchronizer reset to 0.
- tx_rst_n  output  1  TX datapath reset, active-low, registered.
- rx_rst_n  output  1  RX datapath reset, active-low, registered.
- link_up  output  1  high only in state LINK, registered.
- seq_state  output  3  current state encoding.

## Operation
States and encodings:
- IDLE=0
- TX_WAIT=1
- WAIT_REM=2
- RX_WAIT=3
- LINK=4
- Encodings 5–7 are illegal and go to IDLE on the next edge.

Output values by state (all outputs registered from the next-state decode):
- IDLE, TX_WAIT: tx_rst_n=0, rx_rst_n=0, link_up=0.
- WAIT_REM, RX_WAIT: tx_rst_n=1, rx_rst_n=0, link_up=0.
- LINK: tx_rst_n=1, rx_rst_n=1, link_up=1.

Transitions, evaluated each edge in priority order:
1. conf_done=0 in any state other than IDLE → IDLE.
2. sw_rst_req=1 in any state → IDLE.
3. remote_rdy_s=0 in RX_WAIT or LINK → WAIT_REM.
4. IDLE with conf_done=1 → TX_WAIT, counter cleared to 0.
5. TX_WAIT: counter increments each edge; when counter==TX_DLY-1 → WAIT_REM.
6. WAIT_REM with remote_rdy_s=1 → RX_WAIT, counter cleared to 0.
7. RX_WAIT: counter increments each edge; when counter==RX_DLY-1 → LINK.
8. LINK: hold.

Counter rules:
- The counter is CNT_W bits and shared between TX_WAIT and RX_WAIT.
- It is cleared on every state change.
- It never wraps: the terminal compare always fires first.

Reset:
- On rst_n=0: state=IDLE, counter=0, sync flops=0, all outputs 0, seq_state=0.
- Reset mid-sequence aborts immediately and asynchronously.

Scan mode:
- scan_mode=1: tx_rst_n=rx_rst_n=rst_n.
- link_up and seq_state keep reflecting the registers.

## Timing
- Edge E is the edge that samples conf_done=1 in IDLE. tx_rst_n rises at edge E+TX_DLY.
- remote_rdy rising, already in WAIT_REM:
  - remote_rdy_s high after 2 edges.
  - RX_WAIT entered on the 3rd edge, R.
  - rx_rst_n and link_up rise at R+RX_DLY.
- remote_rdy rising before WAIT_REM: RX_WAIT is entered on the edge after WAIT_REM entry.
- remote_rdy_s falling in LINK: rx_rst_n and link_up fall on the next edge; tx_rst_n stays 1.
- sw_rst_req with conf_done held high:
  - all outputs 0 for exactly TX_DLY+1 cycles;
  - then the full sequence reruns.
- If sw_rst_req and a remote drop occur in the same cycle, sw_rst_req wins.
- If conf_done=0 and sw_rst_req occur together, the result is IDLE either way.
- TX_DLY=1: TX_WAIT lasts one cycle.

## Test plan
- Reset release with conf_done=1, remote_rdy=1, TX_DLY=RX_DLY=16:
  - tx_rst_n rises 16 cycles after the first sampling edge;
  - rx_rst_n and link_up rise 16 cycles after RX_WAIT entry;
  - seq_state steps through 0,1,2,3,4.
- remote_rdy held 0:
  - stays in WAIT_REM with tx_rst_n=1, rx_rst_n=0 for 1000 cycles;
  - remote_rdy→1 gives rx_rst_n=1 exactly 2+1+16 edges later.
- remote_rdy pulsed low for 5 cycles in LINK:
  - link_up=0 and rx_rst_n=0 one edge after remote_rdy_s falls;
  - re-link 16 cycles after RX_WAIT re-entry;
  - tx_rst_n never drops.
- sw_rst_req pulse in LINK:
  - all outputs 0 on the next edge;
  - tx_rst_n returns after 17 cycles;
  - the sequence completes again.
- conf_done dropped in RX_WAIT at counter=7: next edge gives IDLE with all outputs 0. Also assert rst_n mid-TX_WAIT: all outputs 0 asynchronously, counter=0.
- scan_mode=1: toggle rst_n and confirm tx_rst_n and rx_rst_n track it combinationally. Also run with TX_DLY=1, RX_DLY=256, CNT_W=8: correct latencies and no counter wrap.
